// File: rtl/pll_clkdiv_model.sv
// Behavioural PLL / clock generator: a lock-delay FSM plus NUM_OUT divided clocks with matching
// one-cycle enables, bypass override and divider reprogramming that only takes effect at a period boundary.
module pll_clkdiv_model #(
    parameter int NUM_OUT     = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 1,
    parameter int LOCK_CYCLES = 64,
    localparam int SEL_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic               REFERENCECLK,
    input  logic               RESETB,
    input  logic               BYPASS,
    input  logic               DIV_LOAD,
    input  logic [SEL_W-1:0]   DIV_SEL,
    input  logic [DIV_W-1:0]   DIV_VAL,
    output logic               LOCK,
    output logic [NUM_OUT-1:0] CLKEN,
    output logic [NUM_OUT-1:0] CLKOUT
);

    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [SEL_W:0]   NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

    typedef enum logic [1:0] {
        LK_WAIT   = 2'd0,
        LK_COUNT  = 2'd1,
        LK_LOCKED = 2'd2
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic [LW-1:0] r_lock_cnt;
    logic [LW-1:0] w_lock_cnt_nxt;
    logic          r_lock;
    logic          w_run;
    logic          w_sel_ok;
    logic [NUM_OUT-1:0] w_clken;
    logic [NUM_OUT-1:0] w_clkout;

    // Lock FSM state, lock counter and registered lock flag
    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state    <= LK_WAIT;
            r_lock_cnt <= {LW{1'b0}};
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock     <= (w_state_nxt == LK_LOCKED);
        end
    end

    // Lock FSM next state: the counter stops at LOCK_CYCLES-1 and never wraps
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            LK_WAIT: begin
                if (r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt = LK_LOCKED;
                end else begin
                    w_state_nxt = LK_COUNT;
                end
            end
            LK_COUNT: begin
                w_lock_cnt_nxt = r_lock_cnt + {{(LW-1){1'b0}}, 1'b1};
                if (w_lock_cnt_nxt == LOCK_LAST) begin
                    w_state_nxt = LK_LOCKED;
                end else begin
                    w_state_nxt = LK_COUNT;
                end
            end
            LK_LOCKED: begin
                w_state_nxt = LK_LOCKED;
            end
            default: begin
                w_state_nxt    = LK_WAIT;
                w_lock_cnt_nxt = {LW{1'b0}};
            end
        endcase
    end

    assign w_run    = r_lock && !BYPASS;
    assign w_sel_ok = ({1'b0, DIV_SEL} < NUM_OUT_L);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_ch
            logic [DIV_W-1:0] r_cnt;
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_shadow;
            logic             r_pend;
            logic             r_clken;
            logic             r_clkout;
            logic             w_load;
            logic             w_wrap;
            logic             w_apply;

            assign w_load  = DIV_LOAD && w_sel_ok && (DIV_SEL == SEL_W'(gi));
            assign w_wrap  = w_run && (r_cnt == r_div);
            // A held channel has no period in flight, so a pending divider may go in at once
            assign w_apply = !w_run || w_wrap;

            // Channel divider counter, strobe, divided clock and shadowed divider value
            always_ff @(posedge REFERENCECLK or negedge RESETB) begin
                if (!RESETB) begin
                    r_cnt    <= {DIV_W{1'b0}};
                    r_div    <= DIV_RST;
                    r_shadow <= DIV_RST;
                    r_pend   <= 1'b0;
                    r_clken  <= 1'b0;
                    r_clkout <= 1'b0;
                end else begin
                    if (!w_run) begin
                        r_cnt    <= {DIV_W{1'b0}};
                        r_clken  <= 1'b0;
                        r_clkout <= 1'b0;
                    end else if (w_wrap) begin
                        r_cnt    <= {DIV_W{1'b0}};
                        r_clken  <= 1'b1;
                        r_clkout <= ~r_clkout;
                    end else begin
                        r_cnt    <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
                        r_clken  <= 1'b0;
                    end

                    if (w_apply && r_pend) begin
                        r_div <= r_shadow;
                    end

                    // A load on the apply cycle itself stays pending for the next boundary
                    if (w_load) begin
                        r_shadow <= DIV_VAL;
                        r_pend   <= 1'b1;
                    end else if (w_apply) begin
                        r_pend   <= 1'b0;
                    end
                end
            end

            assign w_clken[gi]  = r_clken;
            assign w_clkout[gi] = r_clkout;
        end
    endgenerate

    assign LOCK   = r_lock | BYPASS;
    assign CLKEN  = BYPASS ? {NUM_OUT{1'b1}} : w_clken;
    assign CLKOUT = w_clkout;

endmodule

// File: tb/tb_pll_clkdiv_model.sv
// Scoreboard bench for pll_clkdiv_model: a timestamp-based reference model predicts every cycle's
// outputs into a queue and an independent monitor compares them on the falling clock edge.
module tb_pll_clkdiv_model;

    localparam int NC   = 3;
    localparam int DW   = 8;
    localparam int DDIV = 1;
    localparam int LC   = 64;

    logic          clk      = 1'b0;
    logic          resetb   = 1'b0;
    logic          bypass   = 1'b0;
    logic          div_load = 1'b0;
    logic [1:0]    div_sel  = 2'd0;
    logic [DW-1:0] div_val  = 8'd0;
    logic          lock;
    logic [NC-1:0] clken;
    logic [NC-1:0] clkout;

    pll_clkdiv_model #(
        .NUM_OUT    (NC),
        .DIV_W      (DW),
        .DEFAULT_DIV(DDIV),
        .LOCK_CYCLES(LC)
    ) dut (
        .REFERENCECLK(clk),
        .RESETB      (resetb),
        .BYPASS      (bypass),
        .DIV_LOAD    (div_load),
        .DIV_SEL     (div_sel),
        .DIV_VAL     (div_val),
        .LOCK        (lock),
        .CLKEN       (clken),
        .CLKOUT      (clkout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          lock;
        logic [NC-1:0] clken;
        logic [NC-1:0] clkout;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: edge numbers and per-channel "next pulse" timestamps
    int  n_edge = 0;
    int  rel_edge;
    bit  rel_set;
    bit  lock_m;
    int  d_m[NC];
    int  sh_m[NC];
    int  nw_m[NC];
    bit  pend_m[NC];
    bit  act_m[NC];
    bit  ce_m[NC];
    bit  co_m[NC];

    function automatic void model_reset();
        lock_m  = 1'b0;
        rel_set = 1'b0;
        rel_edge = 0;
        for (int i = 0; i < NC; i++) begin
            d_m[i]    = DDIV;
            sh_m[i]   = DDIV;
            nw_m[i]   = 0;
            pend_m[i] = 1'b0;
            act_m[i]  = 1'b0;
            ce_m[i]   = 1'b0;
            co_m[i]   = 1'b0;
        end
    endfunction

    // Advance the model over one rising edge, using the inputs present at that edge
    function automatic void model_edge();
        bit was_locked;
        n_edge++;
        if (!resetb) return;
        if (!rel_set) begin
            rel_set  = 1'b1;
            rel_edge = n_edge;
        end
        was_locked = lock_m;
        for (int i = 0; i < NC; i++) begin
            if (!(was_locked && !bypass)) begin
                act_m[i] = 1'b0;
                ce_m[i]  = 1'b0;
                co_m[i]  = 1'b0;
                if (pend_m[i]) begin
                    d_m[i]    = sh_m[i];
                    pend_m[i] = 1'b0;
                end
            end else begin
                if (!act_m[i]) begin
                    act_m[i] = 1'b1;
                    nw_m[i]  = n_edge + d_m[i];
                end
                if (n_edge == nw_m[i]) begin
                    ce_m[i] = 1'b1;
                    co_m[i] = ~co_m[i];
                    if (pend_m[i]) begin
                        d_m[i]    = sh_m[i];
                        pend_m[i] = 1'b0;
                    end
                    nw_m[i] = n_edge + 1 + d_m[i];
                end else begin
                    ce_m[i] = 1'b0;
                end
            end
            if (div_load && (int'(div_sel) < NC) && (int'(div_sel) == i)) begin
                sh_m[i]   = int'(div_val);
                pend_m[i] = 1'b1;
            end
        end
        lock_m = ((n_edge - rel_edge + 1) >= LC);
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.lock = bypass | lock_m;
        for (int i = 0; i < NC; i++) begin
            e.clken[i]  = bypass | ce_m[i];
            e.clkout[i] = co_m[i];
        end
        exp_q.push_back(e);
    endfunction

    // One cycle: model the edge, then drive the next inputs and predict the resulting outputs
    task automatic tick(input bit ld, input int sel, input int val, input bit byp, input bit rstb);
        @(posedge clk);
        #1;
        model_edge();
        div_load = ld;
        div_sel  = 2'(sel);
        div_val  = 8'(val);
        bypass   = byp;
        resetb   = rstb;
        if (!rstb) model_reset();
        push_exp();
    endtask

    task automatic idle(input int cycles, input bit byp);
        for (int k = 0; k < cycles; k++) tick(1'b0, 0, 0, byp, 1'b1);
    endtask

    // Monitor: pop one prediction per falling edge and compare against the pins
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({lock, clken, clkout} !== {e.lock, e.clken, e.clkout}) begin
                    n_err++;
                    $display("FAIL outputs @%0t: got lock=%b clken=%b clkout=%b, want lock=%b clken=%b clkout=%b",
                             $time, lock, clken, clkout, e.lock, e.clken, e.clkout);
                end
            end
        end
    end

    initial begin
        bit byp_r;
        int val;
        int r;
        model_reset();

        // Power-on reset, release, lock delay and default D=1 clocks
        for (int k = 0; k < 3; k++) tick(1'b0, 0, 0, 1'b0, 1'b0);
        idle(100, 1'b0);

        // Reprogram ch1 to D=4 mid-period, then D=0
        tick(1'b1, 1, 4, 1'b0, 1'b1);
        idle(40, 1'b0);
        tick(1'b1, 1, 0, 1'b0, 1'b1);
        idle(20, 1'b0);

        // Out-of-range select, then two loads before a wrap (last wins)
        tick(1'b1, 2, 20, 1'b0, 1'b1);
        idle(30, 1'b0);
        tick(1'b1, 3, 3, 1'b0, 1'b1);
        tick(1'b1, 2, 3, 1'b0, 1'b1);
        tick(1'b1, 2, 7, 1'b0, 1'b1);
        idle(40, 1'b0);

        // Bypass during the lock count, then again after lock
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        idle(20, 1'b0);
        idle(10, 1'b1);
        idle(50, 1'b0);
        idle(5, 1'b1);
        idle(20, 1'b0);

        // Reset mid-period and relock
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        idle(80, 1'b0);

        // Largest divider on ch0
        tick(1'b1, 0, 255, 1'b0, 1'b1);
        idle(560, 1'b0);
        tick(1'b1, 0, 1, 1'b0, 1'b1);
        idle(10, 1'b0);

        // Randomised loads, bypass toggles and occasional resets
        byp_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) byp_r = ~byp_r;
            if ($urandom_range(0, 399) == 0) begin
                tick(1'b0, 0, 0, byp_r, 1'b0);
                tick(1'b0, 0, 0, byp_r, 1'b0);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 8)       val = $urandom_range(0, 6);
                else if (r == 8) val = 255;
                else             val = $urandom_range(0, 255);
                tick(($urandom_range(0, 7) == 0), $urandom_range(0, 3), val, byp_r, 1'b1);
            end
        end
        idle(20, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
